param_counter: RTL and testbench
================================

# param_counter

Parametrised, general-purpose counter replacing the fixed 4-bit free-running counter used in the DFF/timing exercises. Adds configurable width, a programmable terminal value (modulo-N), up/down direction, parallel load, synchronous clear, wrap or saturate mode, and an optional enable prescaler. It is the standard timebase and event counter for the lab designs: debouncers, display scanners and clock dividers instantiate it rather than hand-coding counters.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX. Must satisfy MAX <= 2**WIDTH-1.
- MODE, MODE_WRAP, MODE_WRAP wraps at the limits; MODE_SAT holds at the limits.
- PRESCALE, 1, number of enabled cycles per count step (1..65535); 1 means step on every enabled cycle.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset nrst, synchronous, active-low.
- en  in  1  count enable (active-high); gates the prescaler and stepping.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0, active-high.
- load  in  1  synchronous parallel load, active-high.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  registered count.
- tc  out  1  combinational terminal flag: (up && count==MAX) || (!up && count==0).
- evt  out  1  registered one-cycle pulse: the previous step hit a limit (wrapped, or was blocked in MODE_SAT).

## Operation
- Priority per rising edge: nrst low > clr > load > step > hold.
- nrst low: count=0, prescaler=0, evt=0. Reset does not depend on en; it always applies.
- clr: count=0, prescaler=0, evt=0.
- load: count = min(load_val, MAX); prescaler=0; evt=0.
- step occurs when en=1 and the prescaler tick is asserted:
  - up, count<MAX: count+1. up, count==MAX: MODE_WRAP -> 0, MODE_SAT -> hold; evt=1 next cycle in both modes.
  - down, count>0: count-1. down, count==0: MODE_WRAP -> MAX, MODE_SAT -> hold; evt=1 next cycle.
- Otherwise count holds, and evt is 0 on the next cycle.
- en=0: count and prescaler freeze; tc still follows count/up.
- Arithmetic is in WIDTH bits; the compare-to-MAX happens before increment, so no intermediate overflow.
- Direction change mid-count takes effect at the next step; the prescaler is not reset.

## Timing
- Reset/clear/load take effect on the edge where sampled; count is valid the following cycle.
- Step latency: one cycle from the tick edge to the updated count.
- With PRESCALE=P and en held high from 0: the first step happens on the P-th enabled edge, then every P enabled edges.
- evt is high for exactly one cycle, coincident with the post-step count value.
- tc is combinational from count and up; it has no extra latency.
- Reset values: count=0, evt=0. tc is 1 after reset if up=1 and MAX=0, or if up=0.

## Structure
- Shared package/include `cnt_defs`: MODE_WRAP=0 and MODE_SAT=1 constants, and the legal-range check macros for WIDTH and PRESCALE.
- Sub-module `prescale_tick`:
  - Parameter PRESCALE; inputs clk, nrst, en, sclr; output tick.
  - Internal counter of $clog2(PRESCALE) bits (minimum 1 bit).
  - tick=en when PRESCALE==1.
  - sclr is driven by clr|load.
- Elaboration-time check: MAX > 2**WIDTH-1 or PRESCALE==0 is a fatal error.

## Test plan
- Reset mid-count: WIDTH=4, MAX=9, count=6, en=1, nrst low one edge -> count=0, evt=0 next cycle, independent of en.
- Wrap up: MAX=9, up=1, en=1 from 0 -> sequence 0..9,0; evt pulses once with count=0; tc=1 while count=9.
- Saturate down: MODE_SAT, up=0, load 2 -> 2,1,0,0,0; evt pulses on each blocked step at 0; count never goes to 9.
- Load clamp and priority: load_val=15 with MAX=9 -> count=9. Assert clr and load in the same cycle -> count=0.
- Prescaler: PRESCALE=3, en=1 -> count increments every 3rd edge. Drop en for 2 cycles -> the step delays by exactly 2 cycles.
- Direction flip at limit: count=9, up=1 -> set up=0 -> tc drops immediately, next step gives 8, and evt stays 0.

Source files
------------

// File: rtl/cnt_defs.sv
// rtl/cnt_defs.sv - shared mode constants and parameter range checks for param_counter
package cnt_defs;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 32;
    localparam int PRESCALE_MIN = 1;
    localparam int PRESCALE_MAX = 65535;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    function automatic bit prescale_ok(input int p);
        return (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
    endfunction

    // Largest count representable in w bits, computed in 64 bits so w=32 cannot overflow.
    function automatic longint unsigned width_limit(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/param_counter_prescale_tick.sv
// rtl/param_counter_prescale_tick.sv - enable prescaler producing one tick every PRESCALE enabled cycles
module prescale_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // With PRESCALE=1, LAST is 0 and cnt never leaves 0, so tick collapses to en.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (sclr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/param_counter.sv
// rtl/param_counter.sv - parametrised up/down modulo-N counter with load, clear, wrap/saturate and prescaler
module param_counter
    import cnt_defs::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              MODE     = MODE_WRAP,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt
);

    if (!width_ok(WIDTH) || !prescale_ok(PRESCALE) || (MAX > width_limit(WIDTH))) begin : g_bad_params
        $fatal(1, "param_counter: illegal WIDTH/MAX/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic tick;
    logic at_lim;
    logic [WIDTH-1:0] next_step;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk  (clk),
        .nrst (nrst),
        .en   (en),
        .sclr (clr | load),
        .tick (tick)
    );

    assign tc     = up ? (count == MAXV) : (count == '0);
    assign at_lim = tc;

    // Limit is tested before the add/subtract, so count never passes through an out-of-range value.
    always_comb begin
        next_step = count;
        if (!at_lim) begin
            next_step = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end else if (MODE == MODE_WRAP) begin
            next_step = up ? '0 : MAXV;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count <= '0;
            evt   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            evt   <= 1'b0;
        end else if (load) begin
            count <= (load_val > MAXV) ? MAXV : load_val;
            evt   <= 1'b0;
        end else if (tick) begin
            count <= next_step;
            evt   <= at_lim;
        end else begin
            evt   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - directed self-checking bench for param_counter (wrap, saturate, prescaled)
module tb_param_counter;
    import cnt_defs::*;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // a: wrap, P=1; b: saturate, P=1; c: wrap, P=3. All WIDTH=4, MAX=9.
    logic       a_en, a_up, a_clr, a_load, a_tc, a_evt;
    logic [3:0] a_lv, a_cnt;
    logic       b_en, b_up, b_clr, b_load, b_tc, b_evt;
    logic [3:0] b_lv, b_cnt;
    logic       c_en, c_up, c_clr, c_load, c_tc, c_evt;
    logic [3:0] c_lv, c_cnt;

    int checks = 0;
    int errors = 0;

    param_counter #(.WIDTH(4), .MAX(9), .MODE(MODE_WRAP), .PRESCALE(1)) u_a (
        .clk(clk), .nrst(nrst), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .count(a_cnt), .tc(a_tc), .evt(a_evt));

    param_counter #(.WIDTH(4), .MAX(9), .MODE(MODE_SAT), .PRESCALE(1)) u_b (
        .clk(clk), .nrst(nrst), .en(b_en), .up(b_up), .clr(b_clr), .load(b_load),
        .load_val(b_lv), .count(b_cnt), .tc(b_tc), .evt(b_evt));

    param_counter #(.WIDTH(4), .MAX(9), .MODE(MODE_WRAP), .PRESCALE(3)) u_c (
        .clk(clk), .nrst(nrst), .en(c_en), .up(c_up), .clr(c_clr), .load(c_load),
        .load_val(c_lv), .count(c_cnt), .tc(c_tc), .evt(c_evt));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int c_exp_cnt [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    int c_exp_en  [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};

    initial begin
        nrst = 1'b0;
        a_en = 0; a_up = 1; a_clr = 0; a_load = 0; a_lv = 0;
        b_en = 0; b_up = 0; b_clr = 0; b_load = 0; b_lv = 0;
        c_en = 0; c_up = 1; c_clr = 0; c_load = 0; c_lv = 0;
        step();
        step();
        check("rst_a_count", a_cnt, 0);
        check("rst_a_evt", a_evt, 0);
        check("rst_a_tc_up", a_tc, 0);
        check("rst_b_tc_down", b_tc, 1);
        check("rst_c_count", c_cnt, 0);
        nrst = 1'b1;

        // wrap up 0..9,0
        a_en = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("wrap_cnt_%0d", i), a_cnt, i % 10);
            check($sformatf("wrap_evt_%0d", i), a_evt, (i == 10));
            check($sformatf("wrap_tc_%0d", i), a_tc, (i == 9));
        end
        step();
        check("wrap_after_cnt", a_cnt, 1);
        check("wrap_after_evt", a_evt, 0);

        // reset mid-count at 6 with en still high
        repeat (5) step();
        check("mid_cnt_before", a_cnt, 6);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check("mid_rst_cnt", a_cnt, 0);
        check("mid_rst_evt", a_evt, 0);

        // load clamp, then clr beats load
        a_en = 0; a_load = 1; a_lv = 4'd15;
        step();
        check("load_clamp", a_cnt, 9);
        a_clr = 1;
        step();
        a_clr = 0; a_load = 0;
        check("clr_over_load", a_cnt, 0);

        // wrap down 0 -> 9
        a_up = 0; a_en = 1;
        step();
        a_en = 0;
        check("wrapdn_cnt", a_cnt, 9);
        check("wrapdn_evt", a_evt, 1);
        step();
        check("wrapdn_evt_clear", a_evt, 0);

        // direction flip at limit
        a_up = 1;
        #1;
        check("flip_tc_up", a_tc, 1);
        a_up = 0;
        #1;
        check("flip_tc_drop", a_tc, 0);
        a_en = 1;
        step();
        a_en = 0;
        check("flip_cnt", a_cnt, 8);
        check("flip_evt", a_evt, 0);

        // saturate down from 2
        b_load = 1; b_lv = 4'd2;
        step();
        b_load = 0;
        check("sat_load", b_cnt, 2);
        b_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("sat_cnt_%0d", i), b_cnt, (i == 0) ? 1 : 0);
            check($sformatf("sat_evt_%0d", i), b_evt, (i >= 2));
        end
        b_en = 0;
        step();
        check("sat_evt_idle", b_evt, 0);

        // saturate up at 9
        b_up = 1; b_load = 1; b_lv = 4'd9;
        step();
        b_load = 0; b_en = 1;
        step();
        b_en = 0;
        check("satup_cnt", b_cnt, 9);
        check("satup_evt", b_evt, 1);

        // prescaler 3, en dropped on edges 7 and 8
        for (int i = 0; i < 11; i++) begin
            c_en = c_exp_en[i][0];
            step();
            check($sformatf("pre_cnt_e%0d", i + 1), c_cnt, c_exp_cnt[i]);
        end
        c_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
